// File: rtl/frame_transmitter.sv
// frame_transmitter: serializes one buffered frame as FRAME_START, byte-stuffed payload, FRAME_END.
// Define FRAME_TX_RETRY_EN to build the confirmation wait and retransmission logic.
module frame_transmitter #(
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned PREAMBLE_SIZE = 7,
  parameter int unsigned CRC_SIZE      = 4,
  parameter logic [7:0]  FRAME_START   = 8'h06,
  parameter logic [7:0]  FRAME_END     = 8'h07,
  parameter logic [7:0]  ESC_VAL       = 8'h14,
  parameter logic [7:0]  ESC_XOR       = 8'h20,
  parameter logic [7:0]  OKAY          = 8'h05,
  parameter logic [7:0]  ERROR         = 8'h04,
  parameter logic [7:0]  FATAL_ERROR   = 8'h08,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned ACK_TIMEOUT   = 1000000
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [0:(PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE)*8-1]    fin,
  input  logic                                               fin_valid,
  output logic                                               fin_ready,
  output logic [7:0]                                         tx_data,
  output logic                                               tx_valid,
  input  logic                                               tx_ready,
  input  logic [7:0]                                         ack_code,
  input  logic                                               ack_valid,
  output logic                                               done,
  output logic [7:0]                                         status
);

  localparam int unsigned NBYTES = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

`ifdef FRAME_TX_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BYTE, S_ESC2, S_END, S_WAIT_ACK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BYTE, S_ESC2, S_END, S_DONE
  } state_t;
`endif

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [0:(PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE)*8-1] frame_q;
  logic                                   load;
  logic                                   byte_xfer;
  logic [7:0]                             cur_byte;
  logic                                   need_esc;

`ifdef FRAME_TX_RETRY_EN
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         status_q, status_d;
`else
  logic unused_ok;
  assign unused_ok = ^{ack_code, ack_valid, ERROR, FATAL_ERROR, 32'(MAX_RETRY), 32'(ACK_TIMEOUT)};
`endif

  assign cur_byte = frame_q[{idx_q, 3'b000} +: 8];
  assign need_esc = (cur_byte == FRAME_START) || (cur_byte == FRAME_END) || (cur_byte == ESC_VAL);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    byte_xfer = 1'b0;
    fin_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    done      = 1'b0;
    status    = '0;
`ifdef FRAME_TX_RETRY_EN
    retry_d   = retry_q;
    timer_d   = timer_q;
    status_d  = status_q;
`endif
    case (state_q)
      S_IDLE: begin
        fin_ready = 1'b1;
        if (fin_valid) begin
          load    = 1'b1;
          idx_d   = '0;
`ifdef FRAME_TX_RETRY_EN
          retry_d = '0;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_START;
        if (tx_ready) state_d = S_BYTE;
      end
      S_BYTE: begin
        tx_valid = 1'b1;
        if (need_esc) begin
          tx_data = ESC_VAL;
          if (tx_ready) state_d = S_ESC2;
        end else begin
          tx_data   = cur_byte;
          byte_xfer = tx_ready;
        end
      end
      S_ESC2: begin
        tx_valid  = 1'b1;
        tx_data   = cur_byte ^ ESC_XOR;
        byte_xfer = tx_ready;
      end
      S_END: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_END;
        if (tx_ready) begin
`ifdef FRAME_TX_RETRY_EN
          timer_d = '0;
          state_d = S_WAIT_ACK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FRAME_TX_RETRY_EN
      S_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        // A confirmation on the timeout cycle takes priority over the timeout.
        if (ack_valid && (ack_code == OKAY)) begin
          status_d = OKAY;
          state_d  = S_DONE;
        end else if ((ack_valid && (ack_code == ERROR)) || (timer_q == TIMER_LAST)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            idx_d   = '0;
            state_d = S_START;
          end else begin
            status_d = FATAL_ERROR;
            state_d  = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
`ifdef FRAME_TX_RETRY_EN
        status  = status_q;
`else
        status  = OKAY;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Plain bytes and the second half of an escape pair advance the index identically.
    if (byte_xfer) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_END;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_BYTE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      frame_q  <= '0;
`ifdef FRAME_TX_RETRY_EN
      retry_q  <= '0;
      timer_q  <= '0;
      status_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      if (load) frame_q <= fin;
`ifdef FRAME_TX_RETRY_EN
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      status_q <= status_d;
`endif
    end
  end

endmodule
